// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master Avalon-MM arbiter in front of the peripheral bridge slave.
// Optional read-response watchdog is built when PERIPH_ARB_TIMEOUT_EN is defined.
module periph_bus_arbiter #(
   parameter int MAX_PEND       = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [8:0]  m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   input  logic        m0_debugaccess,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [8:0]  m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   input  logic        m1_debugaccess,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [8:0]  s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   output logic        s_debugaccess,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   input  logic        s_readdatavalid,
   output logic        arb_err
);

   localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_PEND);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD0 = 2'd1,
      ST_HOLD1 = 2'd2
   } state_e;

   state_e              state_r;
   state_e              state_nxt_s;
   logic                last_grant_r;
   logic                grant_s;
   logic                grant_vld_s;
   logic                req0_s;
   logic                req1_s;
   logic                elig0_s;
   logic                elig1_s;
   logic                sel_read_s;
   logic                sel_write_s;
   logic                fwd_read_s;
   logic                fwd_write_s;
   logic                fwd_any_s;
   logic                accept_s;
   logic                gnt_stall_s;
   logic                push_s;
   logic                pop_s;
   logic                empty_s;
   logic                full_s;
   logic                head_id_s;
   logic                timeout_fire_s;
   logic [31:0]         rsp_data_s;
   logic [MAX_PEND-1:0] id_mem_r;
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    count_r;
   logic                err_set_s;
   logic                arb_err_r;

   assign req0_s  = m0_read | m0_write;
   assign req1_s  = m1_read | m1_write;
   assign empty_s = (count_r == {CNT_W{1'b0}});
   assign pop_s   = (s_readdatavalid & ~empty_s) | timeout_fire_s;
   // A pop in the same cycle frees a slot, so a read may issue alongside it.
   assign full_s  = (count_r == CNT_FULL) & ~pop_s;
   // A read that cannot be forwarded does not compete, so the other master's write is not starved.
   assign elig0_s = m0_write | (m0_read & ~full_s);
   assign elig1_s = m1_write | (m1_read & ~full_s);

   // Grant selection: free arbitration in IDLE, fixed grant while a command is held.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (elig0_s && elig1_s) begin
               grant_vld_s = 1'b1;
               grant_s     = ~last_grant_r;
            end else if (elig0_s) begin
               grant_vld_s = 1'b1;
               grant_s     = 1'b0;
            end else if (elig1_s) begin
               grant_vld_s = 1'b1;
               grant_s     = 1'b1;
            end else begin
               grant_vld_s = 1'b0;
               grant_s     = 1'b0;
            end
         end
         ST_HOLD0: begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b0;
         end
         ST_HOLD1: begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b1;
         end
         default: begin
            grant_vld_s = 1'b0;
            grant_s     = 1'b0;
         end
      endcase
   end

   assign sel_read_s    = grant_s ? m1_read        : m0_read;
   assign sel_write_s   = grant_s ? m1_write       : m0_write;
   assign s_address     = grant_s ? m1_address     : m0_address;
   assign s_writedata   = grant_s ? m1_writedata   : m0_writedata;
   assign s_byteenable  = grant_s ? m1_byteenable  : m0_byteenable;
   assign s_debugaccess = grant_s ? m1_debugaccess : m0_debugaccess;

   // A combined read+write is a protocol error: the write wins and the read is dropped.
   assign fwd_write_s = grant_vld_s & sel_write_s & ~reset_reset;
   assign fwd_read_s  = grant_vld_s & sel_read_s & ~sel_write_s & ~full_s & ~reset_reset;
   assign fwd_any_s   = fwd_read_s | fwd_write_s;
   assign accept_s    = fwd_any_s & ~s_waitrequest;
   assign push_s      = accept_s & fwd_read_s;
   assign gnt_stall_s = ~fwd_any_s | s_waitrequest;
   assign s_read      = fwd_read_s;
   assign s_write     = fwd_write_s;

   assign m0_waitrequest = reset_reset | (req0_s & (~grant_vld_s | grant_s | gnt_stall_s));
   assign m1_waitrequest = reset_reset | (req1_s & (~grant_vld_s | ~grant_s | gnt_stall_s));

   // Next-state logic for the grant FSM.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (fwd_any_s && s_waitrequest) begin
               state_nxt_s = grant_s ? ST_HOLD1 : ST_HOLD0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HOLD0, ST_HOLD1: begin
            if (!fwd_any_s || accept_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state and round-robin history; history moves only on acceptance.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            last_grant_r <= grant_s;
         end
      end
   end

   // Outstanding-read FIFO holding the issuing master ID.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         id_mem_r <= {MAX_PEND{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            id_mem_r[wr_ptr_r] <= grant_s;
            wr_ptr_r           <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   assign head_id_s        = id_mem_r[rd_ptr_r];
   assign m0_readdatavalid = pop_s & ~head_id_s;
   assign m1_readdatavalid = pop_s & head_id_s;
   assign m0_readdata      = rsp_data_s;
   assign m1_readdata      = rsp_data_s;

`ifdef PERIPH_ARB_TIMEOUT_EN
   localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT_CYCLES);
   localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);
   logic [AGE_W-1:0] age_r;

   // A real response in the same cycle takes priority over the watchdog.
   assign timeout_fire_s = ~empty_s & ~s_readdatavalid & (age_r == AGE_LIMIT);
   assign rsp_data_s     = timeout_fire_s ? 32'hDEADBEEF : s_readdata;

   // Age of the FIFO head, counted from the cycle its read was accepted.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         age_r <= {AGE_W{1'b0}};
      end else if (pop_s) begin
         age_r <= {AGE_W{1'b0}};
      end else if (!empty_s || push_s) begin
         age_r <= age_r + AGE_ONE;
      end else begin
         age_r <= {AGE_W{1'b0}};
      end
   end
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^TIMEOUT_CYCLES;
   assign timeout_fire_s   = 1'b0;
   assign rsp_data_s       = s_readdata;
`endif

   assign err_set_s = (s_readdatavalid & empty_s)
                    | (grant_vld_s & sel_read_s & sel_write_s)
                    | timeout_fire_s;

   // Sticky protocol-error flag, cleared only by reset.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         arb_err_r <= 1'b0;
      end else if (err_set_s) begin
         arb_err_r <= 1'b1;
      end else begin
         arb_err_r <= arb_err_r;
      end
   end

   assign arb_err = arb_err_r;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: scenario tasks with a response scoreboard queue.
module tb_periph_bus_arbiter;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic [8:0]  m0_address, m1_address, s_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata, s_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
   logic        m0_debugaccess, m1_debugaccess, s_debugaccess;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        s_read, s_write, s_waitrequest, s_readdatavalid;
   logic [31:0] s_readdata;
   logic        arb_err;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk_clk = ~clk_clk;

   periph_bus_arbiter #(.MAX_PEND(4), .TIMEOUT_CYCLES(16)) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_debugaccess(m0_debugaccess),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_debugaccess(m1_debugaccess),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
      .s_byteenable(s_byteenable), .s_debugaccess(s_debugaccess),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .arb_err(arb_err)
   );

   task automatic cyc();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_clk);
   endtask

   task automatic clear_inputs();
      m0_address = 9'h000; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'h0;
      m0_byteenable = 4'hF; m0_debugaccess = 1'b0;
      m1_address = 9'h000; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'h0;
      m1_byteenable = 4'hF; m1_debugaccess = 1'b0;
      s_waitrequest = 1'b0; s_readdata = 32'h0; s_readdatavalid = 1'b0;
   endtask

   task automatic test_reset();
      m0_read = 1'b1; m1_write = 1'b1;
      smp();
      n_vec++; if (m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_m0_wait got=%b exp=1", m0_waitrequest); end
      n_vec++; if (m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_m1_wait got=%b exp=1", m1_waitrequest); end
      n_vec++; if ({s_read, s_write} !== 2'b00) begin n_err++; $display("FAIL rst_s_cmd got=%b exp=00", {s_read, s_write}); end
      n_vec++; if (arb_err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", arb_err); end
      n_vec++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin n_err++; $display("FAIL rst_rdv got=%b exp=00", {m1_readdatavalid, m0_readdatavalid}); end
      cyc(); reset_reset = 1'b0; m0_read = 1'b0; m1_write = 1'b0;
      smp();
      n_vec++; if ({m1_waitrequest, m0_waitrequest} !== 2'b00) begin n_err++; $display("FAIL post_rst_wait got=%b exp=00", {m1_waitrequest, m0_waitrequest}); end
      n_vec++; if ({s_read, s_write, arb_err} !== 3'b000) begin n_err++; $display("FAIL post_rst_out got=%b exp=000", {s_read, s_write, arb_err}); end
   endtask

   task automatic test_tie_break();
      exp_t e;
      cyc(); m0_read = 1'b1; m0_address = 9'h010; m1_read = 1'b1; m1_address = 9'h020;
      smp();
      n_vec++; if ({s_read, s_address} !== {1'b1, 9'h010}) begin n_err++; $display("FAIL tie_c0_cmd got=%b/%h exp=1/010", s_read, s_address); end
      n_vec++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10) begin n_err++; $display("FAIL tie_c0_wait got=%b exp=10", {m1_waitrequest, m0_waitrequest}); end
      exp_q.push_back({1'b0, 32'h11111111});
      cyc(); m0_read = 1'b0;
      smp();
      n_vec++; if ({s_read, s_address} !== {1'b1, 9'h020}) begin n_err++; $display("FAIL tie_c1_cmd got=%b/%h exp=1/020", s_read, s_address); end
      n_vec++; if (m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL tie_c1_wait got=%b exp=0", m1_waitrequest); end
      exp_q.push_back({1'b1, 32'h22222222});
      for (int i = 0; i < 2; i++) begin
         cyc(); m1_read = 1'b0;
         e = exp_q.pop_front();
         s_readdatavalid = 1'b1; s_readdata = e.data;
         smp();
         n_vec++; if ({m1_readdatavalid, m0_readdatavalid} !== (e.id ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL tie_rsp%0d_rdv got=%b exp_id=%0d", i, {m1_readdatavalid, m0_readdatavalid}, e.id); end
         n_vec++; if ((e.id ? m1_readdata : m0_readdata) !== e.data) begin n_err++; $display("FAIL tie_rsp%0d_data got=%h exp=%h", i, (e.id ? m1_readdata : m0_readdata), e.data); end
      end
      cyc(); s_readdatavalid = 1'b0;
   endtask

   task automatic test_hold();
      exp_t e;
      cyc(); m1_write = 1'b1; m1_address = 9'h1F0; m1_writedata = 32'hCAFE0001;
      m1_byteenable = 4'h3; m1_debugaccess = 1'b1; s_waitrequest = 1'b1;
      smp();
      n_vec++; if ({s_write, s_address, s_writedata} !== {1'b1, 9'h1F0, 32'hCAFE0001}) begin n_err++; $display("FAIL hold_c0_cmd got=%b/%h/%h", s_write, s_address, s_writedata); end
      n_vec++; if ({s_byteenable, s_debugaccess} !== 5'b0011_1) begin n_err++; $display("FAIL hold_c0_be got=%b exp=00111", {s_byteenable, s_debugaccess}); end
      for (int c = 1; c < 5; c++) begin
         cyc(); m0_read = 1'b1; m0_address = 9'h005;
         smp();
         n_vec++; if ({s_write, s_read, s_address} !== {2'b10, 9'h1F0}) begin n_err++; $display("FAIL hold_c%0d_cmd got=%b%b/%h exp=10/1f0", c, s_write, s_read, s_address); end
         n_vec++; if ({m1_waitrequest, m0_waitrequest} !== 2'b11) begin n_err++; $display("FAIL hold_c%0d_wait got=%b exp=11", c, {m1_waitrequest, m0_waitrequest}); end
      end
      cyc(); s_waitrequest = 1'b0;
      smp();
      n_vec++; if ({s_write, s_address} !== {1'b1, 9'h1F0}) begin n_err++; $display("FAIL hold_c5_cmd got=%b/%h exp=1/1f0", s_write, s_address); end
      n_vec++; if ({m1_waitrequest, m0_waitrequest} !== 2'b01) begin n_err++; $display("FAIL hold_c5_wait got=%b exp=01", {m1_waitrequest, m0_waitrequest}); end
      cyc(); m1_write = 1'b0; m1_debugaccess = 1'b0; m1_byteenable = 4'hF;
      smp();
      n_vec++; if ({s_read, s_write, s_address, m0_waitrequest} !== {2'b10, 9'h005, 1'b0}) begin n_err++; $display("FAIL hold_c6_m0 got=%b%b/%h/%b exp=10/005/0", s_read, s_write, s_address, m0_waitrequest); end
      exp_q.push_back({1'b0, 32'h33333333});
      cyc(); m0_read = 1'b0;
      e = exp_q.pop_front();
      s_readdatavalid = 1'b1; s_readdata = e.data;
      smp();
      n_vec++; if ({m1_readdatavalid, m0_readdatavalid, m0_readdata} !== {2'b01, e.data}) begin n_err++; $display("FAIL hold_rsp got=%b/%h exp=01/%h", {m1_readdatavalid, m0_readdatavalid}, m0_readdata, e.data); end
      cyc(); s_readdatavalid = 1'b0;
   endtask

   task automatic test_fifo_full();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         cyc();
         m0_read = ((i % 2) == 0); m1_read = ((i % 2) == 1);
         m0_address = 9'(9'h040 + i); m1_address = 9'(9'h040 + i);
         smp();
         n_vec++; if ({s_read, s_address} !== {1'b1, 9'(9'h040 + i)}) begin n_err++; $display("FAIL full_rd%0d got=%b/%h", i, s_read, s_address); end
         exp_q.push_back({1'(i % 2), 32'(32'hA0000000 + i)});
      end
      cyc(); m1_read = 1'b0; m0_read = 1'b1; m0_address = 9'h044;
      m1_write = 1'b1; m1_address = 9'h100; m1_writedata = 32'h0BADF00D;
      smp();
      n_vec++; if ({s_read, s_write, s_address} !== {2'b01, 9'h100}) begin n_err++; $display("FAIL full_wr_pass got=%b%b/%h exp=01/100", s_read, s_write, s_address); end
      n_vec++; if ({m1_waitrequest, m0_waitrequest} !== 2'b01) begin n_err++; $display("FAIL full_wr_wait got=%b exp=01", {m1_waitrequest, m0_waitrequest}); end
      cyc(); m1_write = 1'b0;
      smp();
      n_vec++; if ({s_read, s_write, m0_waitrequest} !== 3'b001) begin n_err++; $display("FAIL full_stall got=%b exp=001", {s_read, s_write, m0_waitrequest}); end
      cyc();
      e = exp_q.pop_front();
      s_readdatavalid = 1'b1; s_readdata = e.data;
      smp();
      n_vec++; if ({s_read, s_address, m0_waitrequest} !== {1'b1, 9'h044, 1'b0}) begin n_err++; $display("FAIL full_issue_on_pop got=%b/%h/%b exp=1/044/0", s_read, s_address, m0_waitrequest); end
      n_vec++; if ({m1_readdatavalid, m0_readdatavalid, m0_readdata} !== {2'b01, e.data}) begin n_err++; $display("FAIL full_pop0 got=%b/%h exp=01/%h", {m1_readdatavalid, m0_readdatavalid}, m0_readdata, e.data); end
      exp_q.push_back({1'b0, 32'hA0000004});
      for (int i = 0; i < 4; i++) begin
         cyc(); m0_read = 1'b0;
         e = exp_q.pop_front();
         s_readdatavalid = 1'b1; s_readdata = e.data;
         smp();
         n_vec++; if ({m1_readdatavalid, m0_readdatavalid} !== (e.id ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL full_rsp%0d_rdv got=%b exp_id=%0d", i, {m1_readdatavalid, m0_readdatavalid}, e.id); end
         n_vec++; if ((e.id ? m1_readdata : m0_readdata) !== e.data) begin n_err++; $display("FAIL full_rsp%0d_data got=%h exp=%h", i, (e.id ? m1_readdata : m0_readdata), e.data); end
      end
      cyc(); s_readdatavalid = 1'b0;
      smp();
      n_vec++; if (arb_err !== 1'b0) begin n_err++; $display("FAIL full_no_err got=%b exp=0", arb_err); end
   endtask

   task automatic test_spurious();
      cyc(); s_readdatavalid = 1'b1; s_readdata = 32'h55555555;
      smp();
      n_vec++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin n_err++; $display("FAIL spur_rdv got=%b exp=00", {m1_readdatavalid, m0_readdatavalid}); end
      cyc(); s_readdatavalid = 1'b0;
      smp();
      n_vec++; if (arb_err !== 1'b1) begin n_err++; $display("FAIL spur_err got=%b exp=1", arb_err); end
      for (int c = 0; c < 3; c++) begin
         cyc();
         smp();
         n_vec++; if (arb_err !== 1'b1) begin n_err++; $display("FAIL spur_sticky%0d got=%b exp=1", c, arb_err); end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         cyc(); m0_read = 1'b1; m0_address = 9'(9'h060 + i);
         smp();
         n_vec++; if (s_read !== 1'b1) begin n_err++; $display("FAIL rmid_rd%0d got=%b exp=1", i, s_read); end
      end
      cyc(); #3 reset_reset = 1'b1;
      #1;
      n_vec++; if ({m1_waitrequest, m0_waitrequest} !== 2'b11) begin n_err++; $display("FAIL rmid_wait got=%b exp=11", {m1_waitrequest, m0_waitrequest}); end
      n_vec++; if ({s_read, s_write, arb_err} !== 3'b000) begin n_err++; $display("FAIL rmid_out got=%b exp=000", {s_read, s_write, arb_err}); end
      exp_q.delete();
      cyc(); reset_reset = 1'b0; m0_read = 1'b0;
      smp();
      n_vec++; if ({m0_waitrequest, arb_err} !== 2'b00) begin n_err++; $display("FAIL rmid_release got=%b exp=00", {m0_waitrequest, arb_err}); end
      cyc(); s_readdatavalid = 1'b1; s_readdata = 32'h66666666;
      smp();
      n_vec++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin n_err++; $display("FAIL rmid_stale_rdv got=%b exp=00", {m1_readdatavalid, m0_readdatavalid}); end
      cyc(); s_readdatavalid = 1'b0;
      smp();
      n_vec++; if (arb_err !== 1'b1) begin n_err++; $display("FAIL rmid_stale_err got=%b exp=1", arb_err); end
   endtask

   task automatic test_rd_wr_conflict();
      cyc(); reset_reset = 1'b1;
      cyc(); reset_reset = 1'b0; m0_read = 1'b1; m0_write = 1'b1; m0_address = 9'h077;
      smp();
      n_vec++; if ({s_write, s_read, s_address} !== {2'b10, 9'h077}) begin n_err++; $display("FAIL conf_cmd got=%b%b/%h exp=10/077", s_write, s_read, s_address); end
      n_vec++; if ({m0_waitrequest, arb_err} !== 2'b00) begin n_err++; $display("FAIL conf_pre got=%b exp=00", {m0_waitrequest, arb_err}); end
      cyc(); m0_read = 1'b0; m0_write = 1'b0;
      smp();
      n_vec++; if (arb_err !== 1'b1) begin n_err++; $display("FAIL conf_err got=%b exp=1", arb_err); end
      cyc(); s_readdatavalid = 1'b1;
      smp();
      n_vec++; if (m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL conf_dropped_read got=%b exp=0", m0_readdatavalid); end
      cyc(); s_readdatavalid = 1'b0;
   endtask

`ifdef PERIPH_ARB_TIMEOUT_EN
   task automatic test_timeout();
      cyc(); reset_reset = 1'b1;
      cyc(); reset_reset = 1'b0; m0_read = 1'b1; m0_address = 9'h0AA;
      smp();
      n_vec++; if (s_read !== 1'b1) begin n_err++; $display("FAIL tmo_issue got=%b exp=1", s_read); end
      for (int c = 1; c <= 16; c++) begin
         cyc(); m0_read = 1'b0;
         smp();
         if (c < 16) begin
            n_vec++; if (m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL tmo_early%0d got=%b exp=0", c, m0_readdatavalid); end
         end else begin
            n_vec++; if ({m1_readdatavalid, m0_readdatavalid, m0_readdata} !== {2'b01, 32'hDEADBEEF}) begin n_err++; $display("FAIL tmo_fire got=%b/%h exp=01/deadbeef", {m1_readdatavalid, m0_readdatavalid}, m0_readdata); end
         end
      end
      cyc();
      smp();
      n_vec++; if (arb_err !== 1'b1) begin n_err++; $display("FAIL tmo_err got=%b exp=1", arb_err); end
   endtask
`endif

   initial begin
      reset_reset = 1'b1;
      clear_inputs();
      test_reset();
      test_tie_break();
      test_hold();
      test_fifo_full();
      test_spurious();
      test_reset_mid();
      test_rd_wr_conflict();
`ifdef PERIPH_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter that shares the peripheral subsystem's single 32-bit Avalon-MM bridge slave (9-bit word address) between the HPS CPU path (master 0) and a secondary debug/DMA master (master 1). It sits directly in front of the `pb_cpu_0_s0` slave and does three things:
- forwards one master's command at a time;
- tracks outstanding pipelined reads so each `readdatavalid` returns to the master that issued the read;
- flags protocol errors.

## Interface
Parameters:
- `MAX_PEND`, default 4: maximum outstanding reads. Power of 2, range 2..8.
- `TIMEOUT_CYCLES`, default 255: read-response watchdog limit. Used only with `PERIPH_ARB_TIMEOUT_EN`.

Ports (direction, width, meaning):
- `clk_clk` in 1: single clock domain.
- `reset_reset` in 1: asynchronous, active-high reset.
- `m0_address` / `m1_address` in 9: master word address.
- `m0_read` / `m1_read` in 1: read request.
- `m0_write` / `m1_write` in 1: write request.
- `m0_writedata` / `m1_writedata` in 32: write data.
- `m0_byteenable` / `m1_byteenable` in 4: byte enables.
- `m0_debugaccess` / `m1_debugaccess` in 1: debug access qualifier.
- `m0_waitrequest` / `m1_waitrequest` out 1: stall to master.
- `m0_readdata` / `m1_readdata` out 32: read data.
- `m0_readdatavalid` / `m1_readdatavalid` out 1: read response strobe.
- `s_address` out 9, `s_read` out 1, `s_write` out 1, `s_writedata` out 32, `s_byteenable` out 4, `s_debugaccess` out 1: command to the bridge slave.
- `s_waitrequest` in 1, `s_readdata` in 32, `s_readdatavalid` in 1: slave response.
- `arb_err` out 1: sticky error flag.

## Operation
- **Grant FSM:** states IDLE, HOLD0, HOLD1.
  - In IDLE, grant is combinational from the request lines (`mN_read | mN_write`).
  - A sole requester wins.
  - If both request, the master that is not `last_grant` wins. `last_grant` resets to 1, so master 0 wins the first tie.
- **Forwarding:** the granted master's command passes to `s_*` unregistered, adding zero cycles.
  - The non-granted master sees `waitrequest` = 1.
  - When no master is granted, `s_read` = `s_write` = 0.
- **Hold:** if a forwarded command sees `s_waitrequest` = 1, the FSM enters HOLDn. The grant stays fixed until acceptance (`s_read|s_write` and `!s_waitrequest`), then returns to IDLE.
- **Last grant:** `last_grant` updates only on acceptance.
- **Pending FIFO:** `MAX_PEND` deep, 1-bit master ID.
  - Push on each accepted read; pop on `s_readdatavalid`.
  - The popped ID selects which `mN_readdatavalid` to pulse.
  - `s_readdata` is driven to both `mN_readdata` unconditionally.
- **FIFO full:** a read from the granted master is not forwarded (`s_read` = 0) and that master sees `waitrequest` = 1. Writes still proceed.
- **Simultaneous push and pop:** count is unchanged and order is preserved.
- **Spurious response** (`s_readdatavalid` with FIFO empty): no `mN_readdatavalid` is asserted and `arb_err` is set.
- **Simultaneous read and write from one master:** treated as a protocol error. The write is forwarded, the read is dropped, and `arb_err` is set.
- **Writes:** no response is tracked.

## Timing
- **Reset values:** all `waitrequest` = 1 during reset, 0 after (grant is combinational). All `readdatavalid` = 0. `s_read` = `s_write` = 0. `arb_err` = 0. FIFO empty. FSM in IDLE. `last_grant` = 1.
- **Latency:** command path 0 cycles; response path 0 cycles (`s_readdatavalid` to `mN_readdatavalid` is combinational from the FIFO head).
- **Fairness:** back-to-back accepted commands alternate between masters when both request continuously. Each master has at most 1 command of wait due to arbitration.
- **Reset mid-operation:** the FIFO is cleared. Any response arriving afterwards is spurious and sets `arb_err`.

## Configuration
- **`PERIPH_ARB_TIMEOUT_EN` defined:**
  - A counter tracks the age of the FIFO head; it resets on every pop.
  - When the counter reaches `TIMEOUT_CYCLES`, the head is popped and its master gets one `readdatavalid` cycle with `readdata` = `32'hDEADBEEF`. `arb_err` is set.
  - If `s_readdatavalid` arrives in that same cycle, the real response wins and no timeout fires.
- **Not defined:** no counter is built and reads wait indefinitely.

## Test plan
- **Tie-break:** m0 and m1 read simultaneously with `s_waitrequest` = 0 → m0 accepted in cycle 0, m1 in cycle 1. Responses `0x11111111` then `0x22222222` appear on `m0_readdatavalid` then `m1_readdatavalid` respectively.
- **Hold:** m1 write to address `0x1F0` with `s_waitrequest` held high for 5 cycles while m0 requests → grant stays HOLD1, `s_address` = `0x1F0` is stable, and m0 is stalled until cycle 6.
- **FIFO full:** with `MAX_PEND` = 4, issue 4 reads with responses withheld → the 5th read is stalled with `s_read` = 0, while a write from the other master is still accepted. One response then lets the 5th read issue on the same cycle as the pop.
- **Spurious response:** pulse `s_readdatavalid` with the FIFO empty → both `mN_readdatavalid` stay 0 and `arb_err` = 1, remaining set until reset.
- **Reset mid-operation:** assert `reset_reset` with 3 reads pending → outputs go to their reset values immediately (asynchronous). A post-reset response sets `arb_err`.
- **Timeout** (`PERIPH_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16): m0 read never answered → at cycle 16 m0 receives `0xDEADBEEF` and `arb_err` = 1.
